// File: rtl/sva_local_var_checker_pkg.sv
// Shared types and width helpers for the local-variable property checker.
package sva_chk_pkg;

  typedef enum logic [1:0] {
    FAIL_MISMATCH = 2'd0,
    FAIL_EARLY    = 2'd1,
    FAIL_TIMEOUT  = 2'd2,
    FAIL_SPURIOUS = 2'd3
  } fail_code_e;

  localparam int FAIL_CODE_W = 2;

  function automatic int age_w(input int max_dly);
    return $clog2(max_dly + 2);
  endfunction

  function automatic int active_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sva_local_var_checker_if.sv
// Stream-side signals watched by the checker plus its verdict outputs.
interface sva_local_var_checker_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
);
  import sva_chk_pkg::*;

  localparam int ACW = active_w(DEPTH);

  logic                   start_valid;
  logic [DATA_W-1:0]      start_data;
  logic                   resp_valid;
  logic [DATA_W-1:0]      resp_data;

  logic                   pass;
  logic                   fail;
  logic [FAIL_CODE_W-1:0] fail_code;
  logic [DATA_W-1:0]      fail_exp;
  logic [DATA_W-1:0]      fail_got;
  logic                   overflow;
  logic [ACW-1:0]         active_cnt;
  logic [CNT_W-1:0]       pass_cnt;
  logic [CNT_W-1:0]       fail_cnt;

  modport master (
    output start_valid, start_data, resp_valid, resp_data,
    input  pass, fail, fail_code, fail_exp, fail_got, overflow,
           active_cnt, pass_cnt, fail_cnt
  );

  modport slave (
    input  start_valid, start_data, resp_valid, resp_data,
    output pass, fail, fail_code, fail_exp, fail_got, overflow,
           active_cnt, pass_cnt, fail_cnt
  );

endinterface

// File: rtl/sva_local_var_checker_fifo.sv
// In-order circular store of in-flight attempts: captured value x and its age.
module sva_thread_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int AGE_W   = 4,
  parameter int AGE_SAT = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         push_data_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         head_x_o,
  output logic [AGE_W-1:0]          head_age_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [DEPTH-1:0][DATA_W-1:0] x_q;
  logic [DEPTH-1:0][AGE_W-1:0]  age_q;
  logic [PTR_W-1:0]             wptr_q, rptr_q;
  logic [CW-1:0]                cnt_q;

  // Free slots keep aging too; a slot's age is reloaded when it is written.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge clk) begin
      if (rst) begin
        x_q[i]   <= '0;
        age_q[i] <= '0;
      end else if (push_i && wptr_q == PTR_W'(i)) begin
        x_q[i]   <= push_data_i;
        age_q[i] <= AGE_W'(1);
      end else if (age_q[i] != AGE_W'(AGE_SAT)) begin
        age_q[i] <= age_q[i] + AGE_W'(1);
      end
    end
  end

  // Caller guarantees pop only when non-empty and push only when a slot frees.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + PTR_W'(push_i);
      rptr_q <= rptr_q + PTR_W'(pop_i);
      cnt_q  <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_x_o   = x_q[rptr_q];
  assign head_age_o = age_q[rptr_q];
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;

endmodule

// File: rtl/sva_local_var_checker.sv
// Checker for (start_valid, x = start_data) |-> ##[MIN_DLY:MAX_DLY] (resp_valid && resp_data == x).
module sva_local_var_checker
  import sva_chk_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 8,
  parameter int CNT_W   = 16
) (
  input logic                     clk,
  input logic                     rst,
  sva_local_var_checker_if.slave  bus
);

  localparam int AGE_W   = age_w(MAX_DLY);
  localparam int AGE_SAT = MAX_DLY + 1;
  localparam int ACW     = active_w(DEPTH);

  logic [DATA_W-1:0] head_x;
  logic [AGE_W-1:0]  head_age;
  logic              full, empty;
  logic [ACW-1:0]    count;
  logic              push, retire;

  sva_thread_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AGE_W  (AGE_W),
    .AGE_SAT(AGE_SAT)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(bus.start_data),
    .pop_i      (retire),
    .head_x_o   (head_x),
    .head_age_o (head_age),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count)
  );

  logic              pass_d, fail_d, ovf_d;
  fail_code_e        code_d;
  logic [DATA_W-1:0] exp_d, got_d;

  // Only the head is judged; a timeout swallows any coincident response.
  always_comb begin
    retire = 1'b0;
    pass_d = 1'b0;
    fail_d = 1'b0;
    code_d = FAIL_MISMATCH;
    exp_d  = '0;
    got_d  = '0;
    if (empty) begin
      if (bus.resp_valid) begin
        fail_d = 1'b1;
        code_d = FAIL_SPURIOUS;
        got_d  = bus.resp_data;
      end
    end else if (head_age == AGE_W'(AGE_SAT)) begin
      retire = 1'b1;
      fail_d = 1'b1;
      code_d = FAIL_TIMEOUT;
      exp_d  = head_x;
    end else if (bus.resp_valid) begin
      retire = 1'b1;
      exp_d  = head_x;
      got_d  = bus.resp_data;
      if (int'(head_age) < MIN_DLY) begin
        fail_d = 1'b1;
        code_d = FAIL_EARLY;
      end else if (bus.resp_data != head_x) begin
        fail_d = 1'b1;
        code_d = FAIL_MISMATCH;
      end else begin
        pass_d = 1'b1;
      end
    end
  end

  assign push  = bus.start_valid && (!full || retire);
  assign ovf_d = bus.start_valid && full && !retire;

  logic              pass_q, fail_q, ovf_q;
  fail_code_e        code_q;
  logic [DATA_W-1:0] exp_q, got_q;
  logic [CNT_W-1:0]  pass_cnt_q, fail_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      ovf_q      <= 1'b0;
      code_q     <= FAIL_MISMATCH;
      exp_q      <= '0;
      got_q      <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
      ovf_q  <= ovf_d;
      code_q <= fail_d ? code_d : FAIL_MISMATCH;
      exp_q  <= fail_d ? exp_d : '0;
      got_q  <= fail_d ? got_d : '0;
      if (pass_d && pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
      if (fail_d && fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
  assign bus.fail_code  = code_q;
  assign bus.fail_exp   = exp_q;
  assign bus.fail_got   = got_q;
  assign bus.overflow   = ovf_q;
  assign bus.active_cnt = count;
  assign bus.pass_cnt   = pass_cnt_q;
  assign bus.fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_sva_local_var_checker.sv
// Directed and randomized bench with a queue-based reference of the property.
module tb_sva_local_var_checker;
  import sva_chk_pkg::*;

  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int MIN_DLY = 2;
  localparam int MAX_DLY = 8;
  localparam int CNT_W   = 6;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sva_local_var_checker_if #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus();

  sva_local_var_checker #(
    .DATA_W(DW), .DEPTH(DEPTH), .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [DW-1:0] x;
    int            t0;
  } thr_t;

  thr_t          q[$];
  int            cyc = 0;
  int            n_tot = 0, n_pass = 0;
  logic          m_pass, m_fail, m_ovf;
  int            m_code, m_pcnt = 0, m_fcnt = 0;
  logic [DW-1:0] m_exp, m_got;

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // One clock: drive, predict from the queue, clock, compare everything.
  task automatic step(input logic r, input logic sv, input logic [DW-1:0] sd,
                      input logic rv, input logic [DW-1:0] rd);
    int age;
    bit ret;
    rst = r; bus.start_valid = sv; bus.start_data = sd;
    bus.resp_valid = rv; bus.resp_data = rd;
    m_pass = 0; m_fail = 0; m_ovf = 0; m_code = 0; m_exp = '0; m_got = '0; ret = 0;
    if (r) begin
      q.delete(); m_pcnt = 0; m_fcnt = 0;
    end else begin
      if (q.size() == 0) begin
        if (rv) begin m_fail = 1; m_code = 3; m_got = rd; end
      end else begin
        age = cyc - q[0].t0;
        if (age > MAX_DLY) begin
          m_fail = 1; m_code = 2; m_exp = q[0].x; ret = 1;
        end else if (rv) begin
          ret = 1; m_exp = q[0].x; m_got = rd;
          if (age < MIN_DLY)     begin m_fail = 1; m_code = 1; end
          else if (rd != q[0].x) begin m_fail = 1; m_code = 0; end
          else                        m_pass = 1;
        end
      end
      if (ret) void'(q.pop_front());
      if (sv) begin
        if (q.size() < DEPTH) q.push_back('{x: sd, t0: cyc});
        else m_ovf = 1;
      end
      if (m_pass && m_pcnt < CMAX) m_pcnt++;
      if (m_fail && m_fcnt < CMAX) m_fcnt++;
    end
    @(posedge clk);
    #1;
    cmp("pass", bus.pass, m_pass);
    cmp("fail", bus.fail, m_fail);
    cmp("overflow", bus.overflow, m_ovf);
    cmp("active_cnt", bus.active_cnt, q.size());
    cmp("pass_cnt", bus.pass_cnt, m_pcnt);
    cmp("fail_cnt", bus.fail_cnt, m_fcnt);
    if (m_fail) begin
      cmp("fail_code", bus.fail_code, m_code);
      cmp("fail_exp", bus.fail_exp, m_exp);
      cmp("fail_got", bus.fail_got, m_got);
    end
    cyc++;
  endtask

  task automatic idle(); step(0, 0, '0, 0, '0); endtask

  initial begin
    logic r, sv, rv;
    logic [DW-1:0] sd, rd;
    rst = 1'b1; bus.start_valid = 0; bus.start_data = '0; bus.resp_valid = 0; bus.resp_data = '0;
    step(1, 1, 8'hEE, 1, 8'hEE);
    step(1, 0, '0, 0, '0);
    cmp("rst_pass", bus.pass, 0);
    cmp("rst_fail", bus.fail, 0);
    cmp("rst_code", bus.fail_code, 0);
    cmp("rst_exp", bus.fail_exp, 0);
    cmp("rst_got", bus.fail_got, 0);
    cmp("rst_active", bus.active_cnt, 0);

    // single attempt, response at age 3
    idle();
    step(0, 1, 8'hA5, 0, '0);
    idle(); idle();
    step(0, 0, '0, 1, 8'hA5);
    cmp("single_pass", bus.pass, 1);
    cmp("single_pcnt", bus.pass_cnt, 1);
    cmp("single_active", bus.active_cnt, 0);

    // three overlapping attempts, each answered at age 2
    step(0, 1, 8'h01, 0, '0);
    step(0, 1, 8'h02, 0, '0);
    step(0, 1, 8'h03, 1, 8'h01);
    cmp("ovl_pass1", bus.pass, 1);
    step(0, 0, '0, 1, 8'h02);
    cmp("ovl_pass2", bus.pass, 1);
    step(0, 0, '0, 1, 8'h03);
    cmp("ovl_pass3", bus.pass, 1);
    cmp("ovl_pcnt", bus.pass_cnt, 4);
    cmp("ovl_fcnt", bus.fail_cnt, 0);

    // mismatch at age 3, then early at age 1
    step(0, 1, 8'h10, 0, '0);
    idle(); idle();
    step(0, 0, '0, 1, 8'h11);
    cmp("mm_fail", bus.fail, 1);
    cmp("mm_code", bus.fail_code, 0);
    cmp("mm_exp", bus.fail_exp, 8'h10);
    cmp("mm_got", bus.fail_got, 8'h11);
    step(0, 1, 8'h20, 0, '0);
    step(0, 0, '0, 1, 8'h20);
    cmp("early_code", bus.fail_code, 1);
    cmp("early_fail", bus.fail, 1);

    // timeout: age 9 evaluated on the 9th cycle after the start
    step(0, 1, 8'h33, 0, '0);
    for (int k = 1; k <= 9; k++) begin
      idle();
      cmp("to_timing", bus.fail, (k == 9) ? 1 : 0);
    end
    cmp("to_code", bus.fail_code, 2);
    cmp("to_exp", bus.fail_exp, 8'h33);
    cmp("to_got", bus.fail_got, 0);

    // spurious response on an empty FIFO
    step(0, 0, '0, 1, 8'h77);
    cmp("sp_code", bus.fail_code, 3);
    cmp("sp_exp", bus.fail_exp, 0);
    cmp("sp_got", bus.fail_got, 8'h77);

    // overflow on the 5th start; start plus matching retire when full is accepted
    for (int i = 0; i < 5; i++) begin
      step(0, 1, DW'(8'h40 + i), 0, '0);
      cmp("ovf_flag", bus.overflow, (i == 4) ? 1 : 0);
    end
    cmp("ovf_active", bus.active_cnt, 4);
    step(0, 1, 8'h50, 1, 8'h40);
    cmp("full_retire_ovf", bus.overflow, 0);
    cmp("full_retire_pass", bus.pass, 1);
    cmp("full_retire_active", bus.active_cnt, 4);

    // reset mid-flight with three threads
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, DW'(i + 1), 0, '0);
    cmp("mid_active", bus.active_cnt, 3);
    step(1, 1, 8'h99, 1, 8'h01);
    cmp("mid_rst_active", bus.active_cnt, 0);
    cmp("mid_rst_pcnt", bus.pass_cnt, 0);
    cmp("mid_rst_fcnt", bus.fail_cnt, 0);
    step(0, 0, '0, 1, 8'h12);
    cmp("post_rst_code", bus.fail_code, 3);
    cmp("post_rst_fcnt", bus.fail_cnt, 1);

    // fail counter saturation
    for (int i = 0; i < 70; i++) step(0, 0, '0, 1, DW'(i));
    cmp("sat_fcnt", bus.fail_cnt, CMAX);

    // randomized traffic against the reference queue
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 249) == 0);
      sv = ($urandom_range(0, 99) < 40);
      sd = DW'($urandom);
      rv = ($urandom_range(0, 99) < 40);
      rd = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[0].x : DW'($urandom);
      step(r, sv, sd, rv, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
